// File: rtl/dmr_pkg.sv
// -----------------------------------------------------------------------------
// dmr_pkg
// Shared definitions for the MEM-stage data memory responder:
//   - FSM state encoding (IDLE / WAIT / DONE) as fixed 2-bit constants
//   - address-decode helpers (byte-to-word shift, word alignment mask)
//   - wait-counter width helper
// No ports (package).
// -----------------------------------------------------------------------------
package dmr_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Byte address -> word index is a right shift by this amount.
   localparam int          WORD_SHIFT = 2;
   // Low address bits that must be zero for a word access.
   localparam logic [1:0]  ALIGN_MASK = 2'b11;

   // Wait counter must hold WAIT_CYCLES-1; never narrower than one bit.
   function automatic int cnt_width(input int wait_cycles);
      int w;
      w = $clog2(wait_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dmr_storage.sv
// -----------------------------------------------------------------------------
// dmr_storage
// DEPTH x DATA_W word store for the data memory responder.
//   clock  : clock
//   rst    : asynchronous, active-high; clears every word and rdata
//   wr     : write mem[idx] <= wdata on this edge
//   rd     : rdata <= mem[idx] on this edge
//   clr    : rdata <= 0 on this edge (used for stores and illegal accesses)
//   idx    : word index
//   wdata  : store data
//   rdata  : registered read data; holds until the next rd/clr
// -----------------------------------------------------------------------------
module dmr_storage #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 6
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              wr,
   input  logic              rd,
   input  logic              clr,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr) begin
         mem[idx] <= wdata;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (rd) begin
         rdata <= mem[idx];
      end else if (clr) begin
         rdata <= '0;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Target end of the core's MEM-stage load/store interface. Each request is
// held off for WAIT_CYCLES wait states, then completes with a one-cycle
// ready_done pulse. Out-of-range, misaligned or read+write requests complete
// with err instead of touching the store.
//
// Handshake: the core holds mem_r_en/mem_w_en (and address/wdata) until it
// sees ready=1 on a clock edge. ready is 1 in DONE, and in IDLE while no
// request is present; the core's freeze is (mem_r_en|mem_w_en) & ~ready.
// Dropping the request while in WAIT aborts the access (pipeline flush).
//
// Ports:
//   clock, rst        : clock, asynchronous active-high reset
//   mem_r_en/mem_w_en : load / store request
//   address           : byte address
//   wdata             : store data
//   rdata             : load data, valid while ready_done=1, held until next DONE
//   ready             : access complete, or no access pending
//   ready_done        : one-cycle completion pulse (state DONE)
//   err               : one-cycle pulse with ready_done for an illegal access
//   busy              : access in progress (state WAIT)
// -----------------------------------------------------------------------------
module data_mem_responder
   import dmr_pkg::*;
#(
   parameter int          DEPTH       = 64,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 3,
   parameter int          DATA_W      = 32
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [31:0]       address,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              ready_done,
   output logic              err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = cnt_width(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_t            state;
   logic [CNT_W-1:0]  cnt;

   // Access captured in IDLE; WAIT never re-samples the inputs.
   logic              write_q;
   logic              illegal_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] wdata_q;

   // ---------------- address decode ----------------
   logic              req;
   logic [31:0]       offset;
   logic [31:0]       word;
   logic              illegal_now;

   assign req    = mem_r_en | mem_w_en;
   assign offset = address - BASE_ADDR;
   assign word   = offset >> WORD_SHIFT;

   // Below-base addresses wrap offset to a huge word index; the explicit
   // compare keeps the rule readable and independent of that wrap.
   assign illegal_now = (address < BASE_ADDR)
                      | ((address[1:0] & ALIGN_MASK) != 2'b00)
                      | (word >= 32'(DEPTH))
                      | (mem_r_en & mem_w_en);

   // ---------------- completion ----------------
   // With zero wait states DONE is entered straight from IDLE, so the
   // access has to come from the live inputs rather than the latches.
   logic              in_idle;
   logic              enter_done;
   logic              acc_write;
   logic              acc_illegal;
   logic [IDX_W-1:0]  acc_idx;
   logic [DATA_W-1:0] acc_wdata;

   assign in_idle     = (state == ST_IDLE);
   assign acc_write   = in_idle ? mem_w_en            : write_q;
   assign acc_illegal = in_idle ? illegal_now         : illegal_q;
   assign acc_idx     = in_idle ? word[IDX_W-1:0]     : idx_q;
   assign acc_wdata   = in_idle ? wdata               : wdata_q;

   assign enter_done = (in_idle && req && (WAIT_CYCLES == 0))
                     || ((state == ST_WAIT) && req && (cnt == '0));

   // ---------------- FSM ----------------
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         write_q   <= 1'b0;
         illegal_q <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         err       <= 1'b0;
      end else begin
         err <= enter_done & acc_illegal;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  write_q   <= mem_w_en;
                  illegal_q <= illegal_now;
                  idx_q     <= word[IDX_W-1:0];
                  wdata_q   <= wdata;
                  if (WAIT_CYCLES == 0) begin
                     state <= ST_DONE;
                  end else begin
                     cnt   <= CNT_LOAD;
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state <= ST_IDLE;        // flushed: nothing written
               end else if (cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready      = (state == ST_DONE) | (in_idle & ~req);
   assign ready_done = (state == ST_DONE);
   assign busy       = (state == ST_WAIT);

   // ---------------- storage ----------------
   logic st_wr;
   logic st_rd;
   logic st_clr;

   assign st_wr  = enter_done & ~acc_illegal &  acc_write;
   assign st_rd  = enter_done & ~acc_illegal & ~acc_write;
   assign st_clr = enter_done & (acc_illegal | acc_write);

   dmr_storage #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_storage (
      .clock (clock),
      .rst   (rst),
      .wr    (st_wr),
      .rd    (st_rd),
      .clr   (st_clr),
      .idx   (acc_idx),
      .wdata (acc_wdata),
      .rdata (rdata)
   );

endmodule
